// File: rtl/com_line_sel_ctrl.sv
// Command-line source selector for the HSI master: steers cd_q onto one of
// N_LINES redundant command lines and picks the matching reply line.
module com_line_sel_ctrl #(
  parameter int   N_LINES   = 2,
  parameter int   SEL_W     = 1,
  parameter int   ERR_LIMIT = 1,
  parameter logic IDLE_LVL  = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               sync_clr,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   base_sel,
  input  logic               switch_req,
  input  logic               frame_to_reply_end,
  input  logic               cd_q,
  input  logic [N_LINES-1:0] dat,
  output logic [N_LINES-1:0] com,
  output logic               dat_q,
  output logic [SEL_W-1:0]   act_sel,
  output logic               switched,
  output logic               all_failed
);

  // One extra bit so base + offset (< 2*N_LINES) never overflows.
  localparam int IDX_W = SEL_W + 1;
  localparam logic [IDX_W-1:0] N_EXT       = IDX_W'(N_LINES);
  localparam logic [SEL_W-1:0] OFFSET_LAST = SEL_W'(N_LINES - 1);
  localparam logic [4:0]       LIMIT_EXT   = 5'(ERR_LIMIT);

  typedef enum logic [1:0] {
    MODE_FIXED    = 2'b00,
    MODE_ONE_SHOT = 2'b01,
    MODE_STICKY   = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  logic [SEL_W-1:0] offset_reg, offset_next;
  logic [3:0]       err_cnt_reg, err_cnt_next;
  logic             all_failed_reg, all_failed_next;

  logic [IDX_W-1:0] base_ext;
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] sum_idx;
  logic [IDX_W-1:0] act_ext;
  logic [4:0]       err_inc;
  logic             threshold_hit;
  logic             failover_en;
  logic             one_shot;
  logic [N_LINES-1:0] sel_hot;

  // Out-of-range base indices fall back to line 0.
  assign base_ext = {1'b0, base_sel};
  assign base_idx = (base_ext < N_EXT) ? base_ext : '0;
  assign sum_idx  = base_idx + {1'b0, offset_reg};
  assign act_ext  = (sum_idx >= N_EXT) ? (sum_idx - N_EXT) : sum_idx;
  assign act_sel  = act_ext[SEL_W-1:0];

  assign switched   = (offset_reg != '0);
  assign all_failed = all_failed_reg;

  assign failover_en   = (mode_e'(mode) == MODE_ONE_SHOT) || (mode_e'(mode) == MODE_STICKY);
  assign one_shot      = (mode_e'(mode) == MODE_ONE_SHOT);
  assign err_inc       = {1'b0, err_cnt_reg} + 5'd1;
  assign threshold_hit = (err_inc >= LIMIT_EXT);

  generate
    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_line
      assign sel_hot[gi] = (act_sel == SEL_W'(gi));
      assign com[gi]     = sel_hot[gi] ? cd_q : IDLE_LVL;
    end
  endgenerate

  assign dat_q = |(dat & sel_hot);

  always_comb begin
    offset_next     = offset_reg;
    err_cnt_next    = err_cnt_reg;
    all_failed_next = all_failed_reg;
    if (sync_clr) begin
      offset_next     = '0;
      err_cnt_next    = '0;
      all_failed_next = 1'b0;
    end else if (failover_en) begin
      // A switch request in the same cycle as a frame end shadows the frame end.
      if (switch_req) begin
        if (!threshold_hit) begin
          err_cnt_next = err_inc[3:0];
        end else begin
          err_cnt_next = '0;
          if (offset_reg == OFFSET_LAST) begin
            offset_next     = '0;
            all_failed_next = 1'b1;
          end else begin
            offset_next = offset_reg + 1'b1;
          end
        end
      end else if (frame_to_reply_end) begin
        err_cnt_next = '0;
        if (one_shot) begin
          offset_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      offset_reg     <= '0;
      err_cnt_reg    <= '0;
      all_failed_reg <= 1'b0;
    end else begin
      offset_reg     <= offset_next;
      err_cnt_reg    <= err_cnt_next;
      all_failed_reg <= all_failed_next;
    end
  end

endmodule
